// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - request/result bundle between the EX/MEM stage and the HI/LO unit
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, hi_o, lo_o
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with single-cycle multiply/MADD and iterative divide
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MTHI  = 3'b001;
  localparam logic [2:0] OP_MTLO  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;
  localparam logic [2:0] OP_MADD  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DIV_FIX
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_araw;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dz;

  logic               w_busy;
  logic               w_accept;
  logic               w_signed_div;
  logic [2*WIDTH-1:0] w_a_sx;
  logic [2*WIDTH-1:0] w_b_sx;
  logic [2*WIDTH-1:0] w_a_zx;
  logic [2*WIDTH-1:0] w_b_zx;
  logic [2*WIDTH-1:0] w_sprod;
  logic [2*WIDTH-1:0] w_uprod;
  logic [2*WIDTH-1:0] w_madd;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_lo_fix;
  logic [WIDTH-1:0]   w_hi_fix;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = bus.start & (r_state == S_IDLE) & ~bus.flush & (bus.op != OP_NOP);

  // The low 2*WIDTH bits of a product of extended operands are the exact
  // signed (sign-extended) or unsigned (zero-extended) full-width result.
  assign w_a_sx  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign w_b_sx  = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign w_a_zx  = {{WIDTH{1'b0}}, bus.a};
  assign w_b_zx  = {{WIDTH{1'b0}}, bus.b};
  assign w_sprod = w_a_sx * w_b_sx;
  assign w_uprod = w_a_zx * w_b_zx;
  assign w_madd  = {r_hi, r_lo} + w_sprod;

  // Magnitudes for the restoring divider; DIVU passes operands through raw.
  assign w_signed_div = (bus.op == OP_DIV);
  assign w_a_abs = (w_signed_div & bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
  assign w_b_abs = (w_signed_div & bus.b[WIDTH-1]) ? (-bus.b) : bus.b;

  // Partial remainder always stays below the divisor, so WIDTH+1 bits suffice.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};

  assign w_lo_fix = r_dz ? {WIDTH{1'b1}} : (r_qneg ? (-r_quo) : r_quo);
  assign w_hi_fix = r_dz ? r_araw        : (r_rneg ? (-r_rem) : r_rem);

  assign bus.busy  = w_busy;
  assign bus.stall = bus.start & w_busy & ~bus.flush;
  assign bus.done  = r_done;
  assign bus.hi_o  = r_hi;
  assign bus.lo_o  = r_lo;

  // Operation sequencer: immediate HI/LO writes in IDLE, divide steps in DIV_RUN, sign fix and commit in DIV_FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_araw  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.op)
              OP_MTHI: begin
                r_hi   <= bus.a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= bus.a;
                r_done <= 1'b1;
              end
              OP_MULT: begin
                {r_hi, r_lo} <= w_sprod;
                r_done       <= 1'b1;
              end
              OP_MULTU: begin
                {r_hi, r_lo} <= w_uprod;
                r_done       <= 1'b1;
              end
              OP_MADD: begin
                {r_hi, r_lo} <= w_madd;
                r_done       <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_rem   <= '0;
                r_quo   <= w_a_abs;
                r_dvs   <= w_b_abs;
                r_araw  <= bus.a;
                r_qneg  <= w_signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_rneg  <= w_signed_div & bus.a[WIDTH-1];
                r_dz    <= (bus.b == '0);
                r_cnt   <= '0;
                r_state <= S_DIV_RUN;
              end
              default: begin
              end
            endcase
          end
        end
        S_DIV_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= S_DIV_FIX;
            end
          end
        end
        S_DIV_FIX: begin
          if (!bus.flush) begin
            r_lo   <= w_lo_fix;
            r_hi   <= w_hi_fix;
            r_done <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
